core_mem_arbiter: RTL and testbench

- Shares one in-order, pipelined memory bus between the instruction-fetch requester and the data requester of cpu_pipeline.
- Sits between the core's fetch/data request ports and the single SoC memory port.
- Applies fixed data-over-inst priority with an anti-starvation cap, locks each grant until its address handshake, and tracks outstanding transactions so every response returns to the requester that issued it.

---
 rtl/core_mem_arbiter_pkg.sv | 24 ++
 rtl/core_mem_arbiter_if.sv | 24 ++
 rtl/core_mem_arbiter_arb_id_fifo.sv | 62 ++++++
 rtl/core_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and defaults for the core memory arbiter: requester IDs,
// grant-lock states and the default outstanding-transaction depth.
package core_mem_arbiter_pkg;

    localparam int ARB_XLEN        = 32;
    localparam int ARB_OUTSTANDING = 4;
    localparam int ARB_MAX_STREAK  = 4;

    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } arb_lock_e;

    function automatic arb_lock_e lock_for(input arb_id_e id);
        return (id == ARB_ID_DATA) ? LOCK_DATA : LOCK_INST;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Pipelined request/response bus: one address handshake (req/addr_ok) and
// one in-order response strobe (data_ok) per transaction.
interface core_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            wr;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/core_mem_arbiter_arb_id_fifo.sv
// Requester-ID FIFO: remembers which requester owns each accepted but not
// yet answered memory transaction, in issue order.
module arb_id_fifo
    import core_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_OUTSTANDING
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  arb_id_e push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output arb_id_e head_o
);

    localparam int AW = $clog2(DEPTH);

    arb_id_e        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: storage is deliberately not reset; only the pointers and count
    // define validity, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one pipelined memory port between instruction fetch and data access:
// data-first priority with a starvation cap, grant lock, in-order response routing.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int XLEN        = ARB_XLEN,
    parameter int OUTSTANDING = ARB_OUTSTANDING,
    parameter int MAX_STREAK  = ARB_MAX_STREAK
) (
    input  logic                 clk,
    input  logic                 reset,
    core_mem_arbiter_if.slave    inst_bus,
    core_mem_arbiter_if.slave    data_bus,
    core_mem_arbiter_if.master   mem_bus,
    output logic                 err_unexp_resp
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic             ready_q;
    arb_lock_e        lock_q, lock_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic             err_q, err_d;

    arb_id_e          grant;
    logic             mem_req;
    logic             fire;
    logic             pop;
    logic             fifo_full, fifo_empty;
    arb_id_e          fifo_head;

    // Holds all outputs low for the first cycle after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = ARB_ID_INST;
        case (lock_q)
            LOCK_INST: grant = ARB_ID_INST;
            LOCK_DATA: grant = ARB_ID_DATA;
            default: begin
                if (data_bus.req && !(inst_bus.req && streak_q == SW'(MAX_STREAK))) begin
                    grant = ARB_ID_DATA;
                end else begin
                    grant = ARB_ID_INST;
                end
            end
        endcase
    end

    // A pop in the same cycle does not free a slot for a push: full blocks outright.
    assign mem_req = ready_q & (inst_bus.req | data_bus.req) & ~fifo_full;
    assign fire    = mem_req & mem_bus.addr_ok;
    assign pop     = ready_q & mem_bus.data_ok & ~fifo_empty;

    assign mem_bus.req   = mem_req;
    assign mem_bus.wr    = ready_q & ((grant == ARB_ID_DATA) ? data_bus.wr : inst_bus.wr);
    assign mem_bus.wstrb = ready_q ? ((grant == ARB_ID_DATA) ? data_bus.wstrb : inst_bus.wstrb) : '0;
    assign mem_bus.addr  = ready_q ? ((grant == ARB_ID_DATA) ? data_bus.addr  : inst_bus.addr)  : '0;
    assign mem_bus.wdata = ready_q ? ((grant == ARB_ID_DATA) ? data_bus.wdata : inst_bus.wdata) : '0;

    assign inst_bus.addr_ok = fire & (grant == ARB_ID_INST);
    assign data_bus.addr_ok = fire & (grant == ARB_ID_DATA);
    assign inst_bus.data_ok = pop & (fifo_head == ARB_ID_INST);
    assign data_bus.data_ok = pop & (fifo_head == ARB_ID_DATA);
    assign inst_bus.rdata   = ready_q ? mem_bus.rdata : '0;
    assign data_bus.rdata   = ready_q ? mem_bus.rdata : '0;

    assign err_unexp_resp = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q   <= LOCK_NONE;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    // Lock freezes the grant (and so the payload) until the address is accepted.
    always_comb begin
        lock_d = lock_q;
        if (fire) begin
            lock_d = LOCK_NONE;
        end else if (mem_req) begin
            lock_d = lock_for(grant);
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!inst_bus.req) begin
            streak_d = '0;
        end else if (fire && grant == ARB_ID_INST) begin
            streak_d = '0;
        end else if (fire && grant == ARB_ID_DATA && streak_q != SW'(MAX_STREAK)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    assign err_d = err_q | (ready_q & mem_bus.data_ok & fifo_empty);

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fire),
        .push_id_i (grant),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: fetch, priority, lock, starvation cap,
// full FIFO, unexpected response and asynchronous reset.
module tb_core_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_unexp_resp;

    int n_checks = 0;
    int n_pass   = 0;

    core_mem_arbiter_if #(.XLEN(32)) inst_if ();
    core_mem_arbiter_if #(.XLEN(32)) data_if ();
    core_mem_arbiter_if #(.XLEN(32)) mem_if ();

    core_mem_arbiter #(
        .XLEN        (32),
        .OUTSTANDING (4),
        .MAX_STREAK  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_bus       (inst_if.slave),
        .data_bus       (data_if.slave),
        .mem_bus        (mem_if.master),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inst(input logic req, input logic [31:0] addr);
        inst_if.req   = req;
        inst_if.wr    = 1'b0;
        inst_if.wstrb = 4'h0;
        inst_if.addr  = addr;
        inst_if.wdata = 32'h0;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_if.req   = req;
        data_if.wr    = wr;
        data_if.wstrb = wr ? 4'hf : 4'h0;
        data_if.addr  = addr;
        data_if.wdata = wdata;
    endtask

    task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rdata);
        mem_if.addr_ok = aok;
        mem_if.data_ok = dok;
        mem_if.rdata   = rdata;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    // Starvation table: inst_req, data_req, mem_data_ok, then expected
    // data_addr_ok, inst_addr_ok, data_data_ok, inst_data_ok.
    logic [6:0] starve_tbl [8] = '{
        7'b110_1000,
        7'b111_1010,
        7'b111_1010,
        7'b111_1010,
        7'b111_0110,
        7'b111_1001,
        7'b101_0110,
        7'b001_0001
    };

    initial begin
        // Reset held: outputs stay low even with live requests.
        set_inst(1'b1, 32'hBFC0_0000);
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b1, 1'b1, 32'h1234_5678);
        #2;
        check("rst_mem_req", mem_if.req, 0);
        check("rst_inst_aok", inst_if.addr_ok, 0);
        check("rst_rdata", inst_if.rdata, 0);
        check("rst_err", err_unexp_resp, 0);

        tick();
        reset = 1'b0;
        #1;
        check("post_rst_mem_req", mem_if.req, 0);
        check("post_rst_addr", mem_if.addr, 0);

        // Single fetch.
        tick(); set_inst(1'b1, 32'hBFC0_0000); set_mem(1'b1, 1'b0, 32'h0); #1;
        check("f_mem_req", mem_if.req, 1);
        check("f_addr", mem_if.addr, 32'hBFC0_0000);
        check("f_inst_aok", inst_if.addr_ok, 1);
        check("f_data_aok", data_if.addr_ok, 0);
        tick(); set_inst(1'b0, 32'h0); set_mem(1'b0, 1'b0, 32'h0); #1;
        check("f_idle_req", mem_if.req, 0);
        tick(); set_mem(1'b0, 1'b1, 32'h2401_0001); #1;
        check("f_inst_dok", inst_if.data_ok, 1);
        check("f_inst_rdata", inst_if.rdata, 32'h2401_0001);
        check("f_data_dok", data_if.data_ok, 0);

        // Simultaneous requests: data first, then inst; responses in order.
        tick(); set_inst(1'b1, 32'h100); set_data(1'b1, 1'b0, 32'h8000, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0); #1;
        check("s_addr0", mem_if.addr, 32'h8000);
        check("s_data_aok", data_if.addr_ok, 1);
        check("s_inst_aok0", inst_if.addr_ok, 0);
        tick(); set_data(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("s_addr1", mem_if.addr, 32'h100);
        check("s_inst_aok", inst_if.addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0); set_mem(1'b0, 1'b1, 32'hAAAA_0001); #1;
        check("s_data_dok", data_if.data_ok, 1);
        check("s_inst_dok0", inst_if.data_ok, 0);
        check("s_data_rdata", data_if.rdata, 32'hAAAA_0001);
        tick(); set_mem(1'b0, 1'b1, 32'hBBBB_0002); #1;
        check("s_inst_dok", inst_if.data_ok, 1);
        check("s_data_dok1", data_if.data_ok, 0);

        // Backpressure on a data request; inst arrives while data is waiting.
        tick(); set_data(1'b1, 1'b0, 32'h8000, 32'h0); set_mem(1'b0, 1'b0, 32'h0); #1;
        check("b_req", mem_if.req, 1);
        check("b_addr0", mem_if.addr, 32'h8000);
        check("b_data_aok0", data_if.addr_ok, 0);
        tick(); set_inst(1'b1, 32'h100); #1;
        check("b_addr1", mem_if.addr, 32'h8000);
        tick(); #1;
        check("b_addr2", mem_if.addr, 32'h8000);
        tick(); set_mem(1'b1, 1'b0, 32'h0); #1;
        check("b_addr3", mem_if.addr, 32'h8000);
        check("b_data_aok", data_if.addr_ok, 1);
        check("b_inst_aok0", inst_if.addr_ok, 0);
        tick(); set_data(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("b_addr4", mem_if.addr, 32'h100);
        check("b_inst_aok", inst_if.addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0); set_mem(1'b0, 1'b1, 32'h1); #1;
        check("b_data_dok", data_if.data_ok, 1);
        tick(); set_mem(1'b0, 1'b1, 32'h2); #1;
        check("b_inst_dok", inst_if.data_ok, 1);

        // Lock on a stalled inst request must beat a later data request.
        tick(); set_inst(1'b1, 32'h200); set_mem(1'b0, 1'b0, 32'h0); #1;
        check("l_addr0", mem_if.addr, 32'h200);
        tick(); set_data(1'b1, 1'b0, 32'h9000, 32'h0); #1;
        check("l_addr1", mem_if.addr, 32'h200);
        tick(); set_mem(1'b1, 1'b0, 32'h0); #1;
        check("l_inst_aok", inst_if.addr_ok, 1);
        check("l_data_aok0", data_if.addr_ok, 0);
        tick(); set_inst(1'b0, 32'h0); #1;
        check("l_addr2", mem_if.addr, 32'h9000);
        check("l_data_aok", data_if.addr_ok, 1);
        tick(); set_data(1'b0, 1'b0, 32'h0, 32'h0); set_mem(1'b0, 1'b1, 32'h3); #1;
        check("l_inst_dok", inst_if.data_ok, 1);
        tick(); set_mem(1'b0, 1'b1, 32'h4); #1;
        check("l_data_dok", data_if.data_ok, 1);

        // Starvation cap: four data grants, then inst, then the streak restarts.
        for (int k = 0; k < 8; k++) begin
            tick();
            set_inst(starve_tbl[k][6], 32'h300);
            set_data(starve_tbl[k][5], 1'b0, 32'hA000 + 32'(k * 4), 32'h0);
            set_mem(1'b1, starve_tbl[k][4], 32'hC000_0000 + 32'(k));
            #1;
            check($sformatf("st%0d_data_aok", k), data_if.addr_ok, 32'(starve_tbl[k][3]));
            check($sformatf("st%0d_inst_aok", k), inst_if.addr_ok, 32'(starve_tbl[k][2]));
            check($sformatf("st%0d_data_dok", k), data_if.data_ok, 32'(starve_tbl[k][1]));
            check($sformatf("st%0d_inst_dok", k), inst_if.data_ok, 32'(starve_tbl[k][0]));
        end

        // Fill the FIFO with writes; full blocks even when a pop happens.
        for (int i = 0; i < 4; i++) begin
            tick();
            set_data(1'b1, 1'b1, 32'h9000 + 32'(i * 4), 32'hD000_0000 + 32'(i));
            set_mem(1'b1, 1'b0, 32'h0);
            #1;
            check($sformatf("w%0d_data_aok", i), data_if.addr_ok, 1);
            check($sformatf("w%0d_wdata", i), mem_if.wdata, 32'hD000_0000 + 32'(i));
        end
        check("w_wr", mem_if.wr, 1);
        check("w_wstrb", mem_if.wstrb, 32'hf);
        tick(); set_data(1'b1, 1'b1, 32'h9010, 32'hD000_0004); #1;
        check("full_req", mem_if.req, 0);
        check("full_aok", data_if.addr_ok, 0);
        tick(); set_mem(1'b1, 1'b1, 32'h0); #1;
        check("full_pop_req", mem_if.req, 0);
        check("full_pop_dok", data_if.data_ok, 1);
        tick(); set_mem(1'b1, 1'b0, 32'h0); #1;
        check("refill_req", mem_if.req, 1);
        check("refill_aok", data_if.addr_ok, 1);
        check("refill_addr", mem_if.addr, 32'h9010);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_data(1'b0, 1'b0, 32'h0, 32'h0);
            set_mem(1'b0, 1'b1, 32'(i));
            #1;
            check($sformatf("drain%0d_dok", i), data_if.data_ok, 1);
        end

        // Unexpected response with an empty FIFO.
        tick(); set_mem(1'b0, 1'b1, 32'h55); #1;
        check("u_data_dok", data_if.data_ok, 0);
        check("u_inst_dok", inst_if.data_ok, 0);
        check("u_err_pre", err_unexp_resp, 0);
        tick(); set_mem(1'b0, 1'b0, 32'h0); #1;
        check("u_err", err_unexp_resp, 1);
        tick(); #1;
        check("u_err_sticky", err_unexp_resp, 1);

        // Asynchronous reset with a transaction in flight.
        tick(); set_inst(1'b1, 32'h400); set_mem(1'b1, 1'b0, 32'h0); #1;
        check("r_inst_aok", inst_if.addr_ok, 1);
        tick(); set_inst(1'b0, 32'h0); set_data(1'b1, 1'b0, 32'h8800, 32'h0);
        set_mem(1'b1, 1'b1, 32'h77); #1;
        reset = 1'b1;
        #1;
        check("r_mem_req", mem_if.req, 0);
        check("r_data_aok", data_if.addr_ok, 0);
        check("r_inst_dok", inst_if.data_ok, 0);
        check("r_data_dok", data_if.data_ok, 0);
        check("r_rdata", data_if.rdata, 0);
        check("r_err", err_unexp_resp, 0);
        tick(); reset = 1'b0; #1;
        check("r_first_req", mem_if.req, 0);
        tick(); set_data(1'b0, 1'b0, 32'h0, 32'h0); set_mem(1'b0, 1'b1, 32'h88); #1;
        check("r_dropped_dok", inst_if.data_ok, 0);
        tick(); set_mem(1'b0, 1'b0, 32'h0); #1;
        check("r_dropped_err", err_unexp_resp, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
